// File: rtl/addsat_pipe_if.sv
// Stream bundle for addsat_pipe: operand beats in, saturated results out,
// each side with its own valid/ready pair.
interface addsat_pipe_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               cin;
  logic [1:0]         mode;
  logic               sat;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   r;
  logic               co;
  logic [WIDTH/8-1:0] sat_flags;

  modport master (
    output in_valid, a, b, cin, mode, sat, out_ready,
    input  in_ready, out_valid, r, co, sat_flags
  );

  modport slave (
    input  in_valid, a, b, cin, mode, sat, out_ready,
    output in_ready, out_valid, r, co, sat_flags
  );
endinterface

// File: rtl/addsat_pipe.sv
// Two-stage saturating lane adder (unsigned a + signed per-lane delta b)
// with valid/ready flow control and host-visible saturation statistics.
module addsat_pipe #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               resetl,
  addsat_pipe_if.slave       s,
  input  logic               sat_clr,
  output logic [WIDTH/8-1:0] sat_sticky,
  output logic [CNTW-1:0]    sat_count
);
  localparam int NB = WIDTH / 8;

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, sat_q, sat_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             co_q, co_d;
  logic [NB-1:0]    flags_q, flags_d;
  logic [NB-1:0]    sticky_q, sticky_d;
  logic [CNTW-1:0]  count_q, count_d;

  logic             ld1, ld2, xfer_in, xfer_out;
  logic [WIDTH-1:0] sum_raw, res_comb;
  logic [NB-1:0]    byte_c, lane_flag;

  assign ld2      = !v2_q || s.out_ready;
  assign ld1      = !v1_q || ld2;
  assign xfer_in  = s.in_valid && ld1;
  assign xfer_out = v2_q && s.out_ready;

  assign s.in_ready  = ld1;
  assign s.out_valid = v2_q;
  assign s.r         = r_q;
  assign s.co        = co_q;
  assign s.sat_flags = flags_q;
  assign sat_sticky  = sticky_q;
  assign sat_count   = count_q;

  // Byte-wise ripple; the carry is cut wherever a new lane starts.
  always_comb begin
    logic       c;
    logic [8:0] bsum;
    sum_raw = '0;
    byte_c  = '0;
    bsum    = '0;
    c       = cin_q;
    for (int i = 0; i < NB; i++) begin
      if (i != 0 && (mode_q == 2'd2 || (mode_q == 2'd1 && (i % 2) == 0)))
        c = 1'b0;
      bsum = {1'b0, a_q[8*i +: 8]} + {1'b0, b_q[8*i +: 8]} + {8'd0, c};
      sum_raw[8*i +: 8] = bsum[7:0];
      c         = bsum[8];
      byte_c[i] = c;
    end
  end

  // Each byte looks up the carry and delta sign of the top byte of its lane.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    localparam int T16 = gi | 1;
    localparam int TF  = NB - 1;
    logic top_c, top_s;
    always_comb begin
      case (mode_q)
        2'd2: begin
          top_c = byte_c[gi];
          top_s = b_q[8*gi+7];
        end
        2'd1: begin
          top_c = byte_c[T16];
          top_s = b_q[8*T16+7];
        end
        default: begin
          top_c = byte_c[TF];
          top_s = b_q[8*TF+7];
        end
      endcase
    end
    assign lane_flag[gi]       = sat_q & (top_c ^ top_s);
    assign res_comb[8*gi +: 8] = lane_flag[gi] ? {8{top_c}} : sum_raw[8*gi +: 8];
  end

  always_comb begin
    v1_d     = v1_q;
    v2_d     = v2_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    mode_d   = mode_q;
    sat_d    = sat_q;
    r_d      = r_q;
    co_d     = co_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;
    count_d  = count_q;

    if (ld1) v1_d = s.in_valid;
    if (xfer_in) begin
      a_d    = s.a;
      b_d    = s.b;
      cin_d  = s.cin;
      mode_d = s.mode;
      sat_d  = s.sat;
    end
    if (ld2) v2_d = v1_q;
    if (ld2 && v1_q) begin
      r_d     = res_comb;
      co_d    = byte_c[NB-1];
      flags_d = lane_flag;
    end

    // Clear first so a flagged transfer in the same cycle still lands.
    if (sat_clr) begin
      sticky_d = '0;
      count_d  = '0;
    end
    if (xfer_out) begin
      sticky_d = sticky_d | flags_q;
      if ((|flags_q) && (count_d != {CNTW{1'b1}}))
        count_d = count_d + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      mode_q   <= 2'd0;
      sat_q    <= 1'b0;
      r_q      <= '0;
      co_q     <= 1'b0;
      flags_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      mode_q   <= mode_d;
      sat_q    <= sat_d;
      r_q      <= r_d;
      co_q     <= co_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_addsat_pipe.sv
// Directed bench for addsat_pipe (WIDTH=32, 4-bit counter so the count
// ceiling is reachable quickly).
module tb_addsat_pipe;
  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic            clk = 1'b0;
  logic            resetl;
  logic            sat_clr;
  logic [3:0]      sat_sticky;
  logic [CNTW-1:0] sat_count;
  int              total = 0;
  int              bad   = 0;

  addsat_pipe_if #(.WIDTH(WIDTH)) bus ();

  addsat_pipe #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .resetl     (resetl),
    .s          (bus),
    .sat_clr    (sat_clr),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one beat into an empty pipe, check it two edges later; the
  // transfer edge is left to the caller.
  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [1:0] mv, input logic sv,
                         input logic [31:0] er, input logic [3:0] ef, input logic eco);
    bus.in_valid = 1'b1;
    bus.a = av; bus.b = bv; bus.cin = cv; bus.mode = mv; bus.sat = sv;
    chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_ov_early"}, bus.out_valid, 1'b0);
    tick();
    chk({tag, "_ov"}, bus.out_valid, 1'b1);
    chk({tag, "_r"}, bus.r, er);
    chk({tag, "_flags"}, bus.sat_flags, ef);
    chk({tag, "_co"}, bus.co, eco);
    $display("beat %s: r=%08h flags=%b co=%b", tag, bus.r, bus.sat_flags, bus.co);
  endtask

  initial begin
    logic [31:0] exp_r [8];
    logic [31:0] held_r;
    logic        stalled_prev;
    logic        accept, xfer;
    int          tx, rx;

    resetl = 1'b0;
    sat_clr = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.mode = 2'd0; bus.sat = 1'b0; bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_r", bus.r, 32'h0);
    chk("rst_count", sat_count, 4'h0);
    chk("rst_sticky", sat_sticky, 4'h0);
    resetl = 1'b1;
    tick();

    // Byte lanes: overflow, plain, carry-with-negative-delta, overflow.
    run_one("t1_mode2", 32'hF01080FF, 32'h20F00101, 1'b0, 2'd2, 1'b1, 32'hFF0081FF, 4'b1001, 1'b1);
    tick();
    chk("t1_ov_after", bus.out_valid, 1'b0);
    chk("t1_count", sat_count, 4'd1);
    chk("t1_sticky", sat_sticky, 4'b1001);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("clr_count", sat_count, 4'd0);
    chk("clr_sticky", sat_sticky, 4'b0000);

    run_one("t2_mode1", 32'h00051000, 32'hFFF00010, 1'b0, 2'd1, 1'b1, 32'h00001010, 4'b1100, 1'b0);
    tick();
    chk("t2_count", sat_count, 4'd1);
    chk("t2_sticky", sat_sticky, 4'b1100);

    run_one("t3_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'd0, 1'b0, 32'h00000000, 4'b0000, 1'b1);
    tick();
    chk("t3_count", sat_count, 4'd1);
    run_one("t3_sat", 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b1);
    tick();
    chk("t3s_count", sat_count, 4'd2);
    chk("t3s_sticky", sat_sticky, 4'b1111);

    run_one("cin_mode2", 32'h000000FF, 32'h00000000, 1'b1, 2'd2, 1'b1, 32'h000000FF, 4'b0001, 1'b0);
    tick();
    run_one("mode3_full", 32'h0000FFFF, 32'h00000001, 1'b0, 2'd3, 1'b0, 32'h00010000, 4'b0000, 1'b0);
    tick();
    chk("m3_count", sat_count, 4'd3);

    // Eight beats back to back, consumer stalls during cycles 3-5.
    for (int i = 0; i < 8; i++) exp_r[i] = (32'h11111111 * i) + 32'h1;
    tx = 0; rx = 0; stalled_prev = 1'b0; held_r = '0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      bus.in_valid = (tx < 8);
      bus.a = 32'h11111111 * tx;
      bus.b = 32'h1; bus.cin = 1'b0; bus.mode = 2'd0; bus.sat = 1'b0;
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      chk("b2b_in_ready", bus.in_ready, !((tx - rx) == 2 && !bus.out_ready));
      if (stalled_prev) begin
        chk("b2b_hold_ov", bus.out_valid, 1'b1);
        chk("b2b_hold_r", bus.r, held_r);
      end
      xfer = bus.out_valid && bus.out_ready;
      if (xfer) begin
        chk("b2b_r", bus.r, exp_r[rx]);
        $display("b2b beat %0d: r=%08h", rx, bus.r);
      end
      accept = bus.in_valid && bus.in_ready;
      stalled_prev = bus.out_valid && !bus.out_ready;
      held_r = bus.r;
      tick();
      if (accept) tx++;
      if (xfer) rx++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("b2b_all_out", rx, 8);

    // Clear coinciding with a flagged transfer: the set wins.
    run_one("clr_same", 32'hF01080FF, 32'h20F00101, 1'b0, 2'd2, 1'b1, 32'hFF0081FF, 4'b1001, 1'b1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("clrset_count", sat_count, 4'd1);
    chk("clrset_sticky", sat_sticky, 4'b1001);

    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'hFFFFFFFF; bus.b = 32'h1; bus.cin = 1'b0; bus.mode = 2'd0; bus.sat = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("cnt_ceiling", sat_count, 4'hF);
    run_one("cnt_more", 32'hFFFFFFFF, 32'h00000001, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b1);
    tick();
    chk("cnt_nowrap", sat_count, 4'hF);

    // Two beats in flight, then reset between edges.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 32'h00000010; bus.b = 32'h00000020; bus.mode = 2'd0; bus.sat = 1'b0;
    tick();
    bus.a = 32'h00000030;
    tick();
    bus.in_valid = 1'b0;
    chk("full_in_ready", bus.in_ready, 1'b0);
    chk("full_ov", bus.out_valid, 1'b1);
    chk("full_r", bus.r, 32'h00000030);
    #1;
    resetl = 1'b0;
    #1;
    chk("mrst_ov", bus.out_valid, 1'b0);
    chk("mrst_in_ready", bus.in_ready, 1'b1);
    chk("mrst_count", sat_count, 4'h0);
    chk("mrst_sticky", sat_sticky, 4'h0);
    chk("mrst_r", bus.r, 32'h0);
    #1;
    resetl = 1'b1;
    bus.out_ready = 1'b1;
    run_one("post_rst", 32'h00051000, 32'hFFF00010, 1'b0, 2'd1, 1'b1, 32'h00001010, 4'b1100, 1'b0);
    tick();
    chk("post_rst_count", sat_count, 4'd1);
    chk("post_rst_ov", bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addsat_pipe.md
# addsat_pipe

Pipelined, parametrised saturating adder: the successor to the 16-bit colour/intensity adder. Adds an unsigned operand `a` to a two's-complement delta `b` over WIDTH bits. The sum is split into independent 8-bit, 16-bit or full-width lanes, and each lane can saturate. Sits between the pixel-data path and the write-back buffer, with a valid/ready handshake and two-stage latency, plus saturation statistics for the host.

## Interface
- WIDTH, 32, datapath width; multiple of 16, at least 16
- CNTW, 16, width of saturation event counter
- clk  in  1  system clock, all state on rising edge
- resetl  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  unsigned operand
- b  in  WIDTH  signed delta, per lane
- cin  in  1  carry into bit 0 (lane 0 only)
- mode  in  2  0 full width, 1 16-bit lanes, 2 8-bit lanes, 3 treated as 0
- sat  in  1  saturation enable for this beat
- out_valid  out  1  result beat present
- out_ready  in  1  consumer takes beat
- r  out  WIDTH  result
- co  out  1  raw carry out of most significant lane
- sat_flags  out  WIDTH/8  per-byte saturation flags for the current output beat
- sat_sticky  out  WIDTH/8  accumulated flags since last clear
- sat_count  out  CNTW  number of transferred beats with any flag set
- sat_clr  in  1  synchronous clear of sat_sticky and sat_count

## Operation
- Stage 1 registers `a`, `b`, `cin`, `mode` and `sat` on an input transfer (`in_valid & in_ready`).
- Stage 2 computes the result from the stage-1 registers and registers `r`, `co` and `sat_flags`.
- Lane sums:
  - A lane boundary blocks carry.
  - `cin` enters lane 0 only.
  - Carry into every other lane is 0.
- Per lane, with c = carry out of the lane and s = MSB of the lane's `b`: the lane saturates iff `sat & (c ^ s)`.
- A saturated lane outputs all c: all ones on overflow, all zeros on underflow. Otherwise it outputs the sum bits.
- `co` is the carry out of the top lane, before saturation, and is independent of `sat`.
- `sat_flags` is per byte. In 16-bit and full-width modes, a lane's flag is replicated on every byte of that lane.
- On each output transfer (`out_valid & out_ready`):
  - `sat_sticky |= sat_flags`.
  - If any flag is set, `sat_count` increments, saturating at all ones with no wrap.
- `sat_clr`:
  - Clears `sat_sticky` and `sat_count`.
  - If a transfer in the same cycle carries flags, the result is `sat_sticky` = those flags and `sat_count` = 1. The set wins over the clear.

## Timing
- Reset (`resetl` low, asynchronous) clears all stage valid bits and zeroes `r`, `co`, `sat_flags`, `sat_sticky` and `sat_count`.
  - Outputs after reset: `out_valid`=0, `in_ready`=1.
  - Data in flight when reset asserts mid-operation is discarded.
- Latency: a beat accepted on edge N is presented on `out_valid` after edge N+1, if not stalled.
- Stall rules:
  - Stage 2 loads when it is empty or `out_ready`=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - `in_ready` = !v1 | !v2 | `out_ready`. It is combinational from `out_ready` only.
- Throughput: one beat per cycle with `out_ready` held high.
- While `out_valid`=1 and `out_ready`=0, `r`, `co` and `sat_flags` hold stable. No beat is dropped or duplicated.
- Two beats can be buffered. `in_ready` drops only when both stages are full and `out_ready`=0.
- A `mode` change between consecutive beats takes effect per beat. There are no bubbles.

## Test plan
- WIDTH=32, mode 2, sat 1, a=0xF01080FF, b=0x20F00101 -> r=0xFF0081FF, sat_flags=4'b1001, co=1, out_valid two edges after accept.
- Mode 1, sat 1, a=0x00051000, b=0xFFF00010 -> r=0x00001010, sat_flags=4'b1100, co=0, then sat_count=1 and sat_sticky=4'b1100 after transfer.
- Mode 0, sat 0, a=0xFFFFFFFF, b=0x00000001, cin 0 -> r=0x00000000, co=1, sat_flags=0. Repeat with sat 1 -> r=0xFFFFFFFF, flags 4'hF.
- Back-to-back 8 beats with `out_ready` low for cycles 3-5 -> `in_ready` low only when both stages are full, outputs stable while stalled, all 8 results in order.
- `sat_clr` in the same cycle as a flagged transfer -> sat_count=1, sat_sticky equals that beat's flags. Force the count to all ones -> it holds at all ones.
- Assert `resetl` low with two beats in flight -> `out_valid`=0 and counters zero immediately. After release, the first new beat completes normally.
